// File: rtl/timer_pkg.sv
// timer_pkg: shared state type, display limits and widths for the countdown timer.
package timer_pkg;

  localparam int TIME_W = 8;

  localparam logic [TIME_W-1:0] SEC_MAX = 8'd59;
  localparam logic [TIME_W-1:0] MIN_MAX = 8'd99;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  // Saturate a preset value to the largest displayable digit pair.
  function automatic logic [TIME_W-1:0] clamp_to(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to one tick every TICK_DIV cycles.
// The tick output is the wrap condition of the count; the caller registers it.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  if (TICK_DIV < 2) begin : g_bad_div
    $error("tick_prescaler: TICK_DIV must be at least 2");
  end

  // A clear in the same cycle pre-empts the wrap, so no tick is reported.
  assign tick = en && !clr && (count_q == LAST);

  // Next count: clear wins, otherwise advance and wrap while enabled, else hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: mm:ss countdown timer with start/stop/clear/load commands.
// Optional expiry alarm is compiled in with macro TIMER_CTRL_ALARM_EN.
//
//   state | meaning
//   IDLE  | value loaded or cleared, prescaler held
//   RUN   | counting down, one decrement per tick
//   PAUSE | counting suspended, prescaler count held
//   DONE  | reached 00:00, expired asserted
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned ALARM_TICKS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              load,
  input  logic [TIME_W-1:0] load_min,
  input  logic [TIME_W-1:0] load_sec,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] sec,
  output logic              running,
  output logic              expired,
  output logic              alarm,
  output logic              tick
);

  timer_state_t      state_q, state_d;
  logic [TIME_W-1:0] min_q, min_d, sec_q, sec_d;
  logic              tick_q;
  logic              wrap, presc_en, presc_clr;
  logic              at_zero, last_sec, load_act, start_idle, dec;

  if (ALARM_TICKS < 1) begin : g_bad_alarm
    $error("timer_ctrl: ALARM_TICKS must be at least 1");
  end

  assign at_zero    = (min_q == '0) && (sec_q == '0);
  assign last_sec   = (min_q == '0) && (sec_q == TIME_W'(1));
  // load is ignored in RUN but still outranks stop/start there.
  assign load_act   = load && !clear && (state_q != RUN);
  assign start_idle = start && !clear && !load && !stop && (state_q == IDLE) && !at_zero;
  assign dec        = wrap && (state_q == RUN) && !clear;
  assign presc_clr  = clear || load_act || start_idle;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .reset(reset),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (wrap)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: clear > load > expiry > stop > start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (load_act) begin
      state_d = IDLE;
    end else if (dec && last_sec) begin
      state_d = DONE;
    end else if (!load && stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (!load && start) begin
      if ((state_q == IDLE && !at_zero) || state_q == PAUSE) state_d = RUN;
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    running = (state_q == RUN);
    expired = (state_q == DONE);
  end

  // Time value: clear, clamped load, or borrow-style decrement on a tick.
  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (clear) begin
      min_d = '0;
      sec_d = '0;
    end else if (load_act) begin
      min_d = clamp_to(load_min, MIN_MAX);
      sec_d = clamp_to(load_sec, SEC_MAX);
    end else if (dec) begin
      if (sec_q != '0) begin
        sec_d = sec_q - 1'b1;
      end else begin
        min_d = min_q - 1'b1;
        sec_d = SEC_MAX;
      end
    end
  end

  // Time and tick registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_q  <= '0;
      sec_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      sec_q  <= sec_d;
      tick_q <= wrap;
    end
  end

  assign min  = min_q;
  assign sec  = sec_q;
  assign tick = tick_q;

`ifdef TIMER_CTRL_ALARM_EN
  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic          alarm_q, alarm_d;

  // The prescaler keeps ticking in DONE so the alarm can time itself out.
  assign presc_en = (state_q == RUN) || (state_q == DONE);

  // Alarm rises with expiry and falls after ALARM_TICKS ticks, or at once on clear/load.
  always_comb begin
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;
    if (clear || load_act) begin
      alarm_d     = 1'b0;
      alarm_cnt_d = '0;
    end else if (dec && last_sec) begin
      alarm_d     = 1'b1;
      alarm_cnt_d = AW'(ALARM_TICKS);
    end else if (alarm_q && wrap && (state_q == DONE)) begin
      alarm_cnt_d = alarm_cnt_q - 1'b1;
      if (alarm_cnt_q == AW'(1)) alarm_d = 1'b0;
    end
  end

  // Alarm registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign alarm = alarm_q;
`else
  assign presc_en = (state_q == RUN);
  assign alarm    = 1'b0;
`endif

endmodule
